// File: rtl/riscv_pipe_pkg.sv
// Shared types for the pipeline hazard logic: the per-stage shadow slot
// that remembers which register an in-flight instruction will write.
package riscv_pipe_pkg;

    // Widest register address a shadow slot can hold; narrower addresses are zero-extended.
    localparam int REG_AW_MAX = 8;

    typedef struct packed {
        logic                  valid;
        logic [REG_AW_MAX-1:0] rd;
        logic                  regwrite;
        logic                  memread;
    } shadow_slot_t;

    // x0 is hard-wired zero and never carries a dependency.
    localparam logic [REG_AW_MAX-1:0] REG_X0 = '0;

endpackage

// File: rtl/pipe_shadow_slot.sv
// One shadow slot register: loads d_i when enabled, loads an empty slot
// when enabled together with clr_i, holds otherwise.
module pipe_shadow_slot
    import riscv_pipe_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic         clr_i,
    input  shadow_slot_t d_i,
    output shadow_slot_t q_o
);

    shadow_slot_t r_slot;

    // Slot register: advances with the pipe, empties on a bubble, clears on reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_slot <= '0;
        end else if (en_i) begin
            r_slot <= clr_i ? shadow_slot_t'('0) : d_i;
        end
    end

    assign q_o = r_slot;

endmodule

// File: rtl/hazard_stall_unit.sv
// Hazard stall unit: shadows the destination of the EX and MEM instructions
// and stalls the ID instruction whenever forwarding cannot supply its operands
// (load-use, or a branch resolved in ID that depends on a recent ALU op/load).
// A data-memory wait freezes the whole pipe and takes priority over a stall.
// Optional build macro HAZARD_PERF_CNT_EN adds a saturating bubble-cycle counter
// on stall_cnt_o (and its width parameter CNT_W).
module hazard_stall_unit
    import riscv_pipe_pkg::*;
#(
    parameter int REG_AW = 5
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int CNT_W  = 32
`endif
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_id_i,
    input  logic [REG_AW-1:0] rs1_addr_id_i,
    input  logic [REG_AW-1:0] rs2_addr_id_i,
    input  logic              use_rs1_id_i,
    input  logic              use_rs2_id_i,
    input  logic              branch_id_i,
    input  logic [REG_AW-1:0] rd_addr_id_i,
    input  logic              regwrite_id_i,
    input  logic              memread_id_i,
    input  logic              mem_busy_i,
    output logic              pc_write_o,
    output logic              ifid_write_o,
    output logic              idex_bubble_o,
    output logic              pipe_freeze_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt_o
`endif
);

    shadow_slot_t          w_id_slot;
    shadow_slot_t          w_ex_slot;
    shadow_slot_t          w_mem_slot;
    logic [REG_AW_MAX-1:0] w_rs1;
    logic [REG_AW_MAX-1:0] w_rs2;
    logic                  w_ex_match;
    logic                  w_mem_match;
    logic                  w_load_use;
    logic                  w_branch_alu;
    logic                  w_branch_ld;
    logic                  w_hazard;
    logic                  w_freeze;
    logic                  w_ex_clr;

    // True when slot s will write a register the ID instruction actually reads.
    function automatic logic slot_match(input shadow_slot_t          s,
                                        input logic [REG_AW_MAX-1:0] rs1,
                                        input logic [REG_AW_MAX-1:0] rs2,
                                        input logic                  use1,
                                        input logic                  use2);
        return s.valid && s.regwrite && (s.rd != REG_X0) &&
               ((use1 && (s.rd == rs1)) || (use2 && (s.rd == rs2)));
    endfunction

    assign w_rs1 = REG_AW_MAX'(rs1_addr_id_i);
    assign w_rs2 = REG_AW_MAX'(rs2_addr_id_i);

    assign w_id_slot.valid    = valid_id_i;
    assign w_id_slot.rd       = REG_AW_MAX'(rd_addr_id_i);
    assign w_id_slot.regwrite = regwrite_id_i;
    assign w_id_slot.memread  = memread_id_i;

    assign w_freeze = mem_busy_i;
    // A bubble or an empty ID stage enters EX as an all-zero slot.
    assign w_ex_clr = idex_bubble_o || !valid_id_i;

    pipe_shadow_slot u_ex_slot (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (!w_freeze),
        .clr_i (w_ex_clr),
        .d_i   (w_id_slot),
        .q_o   (w_ex_slot)
    );

    pipe_shadow_slot u_mem_slot (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (!w_freeze),
        .clr_i (1'b0),
        .d_i   (w_ex_slot),
        .q_o   (w_mem_slot)
    );

    assign w_ex_match  = slot_match(w_ex_slot,  w_rs1, w_rs2, use_rs1_id_i, use_rs2_id_i);
    assign w_mem_match = slot_match(w_mem_slot, w_rs1, w_rs2, use_rs1_id_i, use_rs2_id_i);

    // Load data is only available after MEM, so an EX load always costs a cycle;
    // an ID branch also needs EX ALU results and MEM load results one cycle later.
    assign w_load_use   = w_ex_match && w_ex_slot.memread;
    assign w_branch_alu = branch_id_i && w_ex_match && !w_ex_slot.memread;
    assign w_branch_ld  = branch_id_i && w_mem_match && w_mem_slot.memread;
    assign w_hazard     = valid_id_i && (w_load_use || w_branch_alu || w_branch_ld);

    assign pipe_freeze_o = w_freeze;

    // Pipeline enables: a memory wait freezes everything, otherwise a hazard stalls front and bubbles EX.
    always_comb begin
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        idex_bubble_o = 1'b0;
        if (w_freeze) begin
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
        end else if (w_hazard) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    // Count bubble cycles, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stall_cnt <= '0;
        end else if (idex_bubble_o && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`endif

endmodule
